// File: rtl/regfile_pkg.sv
// Shared sizing constants for the register file and its write scoreboard.
package regfile_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned NUM_REGS        = 32;
  localparam int unsigned REG_ADDR_W      = 5;
  localparam int unsigned MAX_PENDING_DEF = 3;

endpackage

// File: rtl/pending_counter.sv
// Saturating in-flight write counter for one architectural register.
module pending_counter #(
  parameter  int unsigned MAX_PENDING = 3,
  localparam int unsigned CNT_W       = $clog2(MAX_PENDING + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic i_inc,
  input  logic i_dec_a,
  input  logic i_dec_b,
  output logic o_busy_c,
  output logic o_full_c,
  output logic o_underflow_c
);

  localparam int unsigned SUM_W = CNT_W + 1;

  logic [CNT_W-1:0] r_cnt;
  logic [SUM_W-1:0] w_up;
  logic [SUM_W-1:0] w_down;
  logic [SUM_W-1:0] w_next_raw;
  logic [CNT_W-1:0] w_next;
  logic             w_underflow;

  // Sum all same-cycle events; clamp at zero on underflow and at MAX_PENDING on overflow.
  always_comb begin
    w_up        = SUM_W'(r_cnt) + SUM_W'(i_inc);
    w_down      = SUM_W'(i_dec_a) + SUM_W'(i_dec_b);
    w_underflow = (w_down > w_up);
    w_next_raw  = w_underflow ? '0 : (w_up - w_down);
    w_next      = (w_next_raw > SUM_W'(MAX_PENDING)) ? CNT_W'(MAX_PENDING)
                                                     : CNT_W'(w_next_raw);
  end

  // Busy and full account for decrements arriving this cycle.
  assign o_busy_c      = (SUM_W'(r_cnt) > w_down);
  assign o_full_c      = (r_cnt == CNT_W'(MAX_PENDING)) && !i_dec_a && !i_dec_b;
  assign o_underflow_c = w_underflow;

  // Counter state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_cnt <= '0;
    else        r_cnt <= w_next;
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// 31x32 register file with per-register pending-write scoreboard and writeback bypass.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned MAX_PENDING = MAX_PENDING_DEF,
  parameter logic        BYPASS_EN   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic [XLEN-1:0]       rs1_data,
  output logic [XLEN-1:0]       rs2_data,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  wb_we,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic                  issue_ready,
  input  logic                  cancel_valid,
  input  logic [REG_ADDR_W-1:0] cancel_rd,
  output logic                  sb_error
);

  logic [XLEN-1:0]       r_regs [1:NUM_REGS-1];
  logic                  r_sb_error;

  logic [NUM_REGS-1:1]   w_inc;
  logic [NUM_REGS-1:1]   w_wb_dec;
  logic [NUM_REGS-1:1]   w_cx_dec;
  logic [NUM_REGS-1:1]   w_busy;
  logic [NUM_REGS-1:1]   w_full;
  logic [NUM_REGS-1:1]   w_underflow;

  logic                  w_wb_fire;
  logic                  w_issue_fire;
  logic                  w_full_sel;
  logic [XLEN-1:0]       w_rs1_rd;
  logic [XLEN-1:0]       w_rs2_rd;
  logic                  w_rs1_busy;
  logic                  w_rs2_busy;

  assign w_wb_fire    = wb_we && (wb_addr != '0);
  assign w_issue_fire = issue_valid && (issue_rd != '0) && issue_ready;

  // One counter per architectural register; x0 has none.
  for (genvar g = 1; g < NUM_REGS; g++) begin : g_cnt
    assign w_inc[g]    = w_issue_fire && (issue_rd == REG_ADDR_W'(g));
    assign w_wb_dec[g] = w_wb_fire && (wb_addr == REG_ADDR_W'(g));
    assign w_cx_dec[g] = cancel_valid && (cancel_rd == REG_ADDR_W'(g));

    pending_counter #(
      .MAX_PENDING (MAX_PENDING)
    ) u_cnt (
      .clk           (clk),
      .reset         (reset),
      .i_inc         (w_inc[g]),
      .i_dec_a       (w_wb_dec[g]),
      .i_dec_b       (w_cx_dec[g]),
      .o_busy_c      (w_busy[g]),
      .o_full_c      (w_full[g]),
      .o_underflow_c (w_underflow[g])
    );
  end

  // Select read data, busy and full for the addressed registers; x0 matches nothing.
  always_comb begin
    w_rs1_rd   = '0;
    w_rs2_rd   = '0;
    w_rs1_busy = 1'b0;
    w_rs2_busy = 1'b0;
    w_full_sel = 1'b0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (rs1_addr == REG_ADDR_W'(i)) begin
        w_rs1_rd   = r_regs[i];
        w_rs1_busy = w_busy[i];
      end
      if (rs2_addr == REG_ADDR_W'(i)) begin
        w_rs2_rd   = r_regs[i];
        w_rs2_busy = w_busy[i];
      end
      if (issue_rd == REG_ADDR_W'(i)) w_full_sel = w_full[i];
    end
  end

  // Writeback bypass; reads are forced to zero while reset is held.
  always_comb begin
    rs1_data = w_rs1_rd;
    rs2_data = w_rs2_rd;
    if (BYPASS_EN && w_wb_fire && (wb_addr == rs1_addr)) rs1_data = wb_data;
    if (BYPASS_EN && w_wb_fire && (wb_addr == rs2_addr)) rs2_data = wb_data;
    if (!reset) begin
      rs1_data = '0;
      rs2_data = '0;
    end
  end

  assign rs1_busy    = w_rs1_busy;
  assign rs2_busy    = w_rs2_busy;
  assign issue_ready = !w_full_sel;
  assign sb_error    = r_sb_error;

  // Register storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (w_wb_fire && (wb_addr == REG_ADDR_W'(i))) r_regs[i] <= wb_data;
      end
    end
  end

  // Sticky underflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_sb_error <= 1'b0;
    else        r_sb_error <= r_sb_error || (|w_underflow);
  end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter MAX_PENDING, default 3: maximum in-flight writes tracked per register; pending-counter width = clog2(MAX_PENDING+1).
REQ-002 Parameter BYPASS_EN, default 1: enables same-cycle writeback-to-read bypass.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous active-low reset.
REQ-006 rs1_addr, rs2_addr  in  5 each  decode-stage source register indices.
REQ-007 rs1_data, rs2_data  out  32 each  source operand values.
REQ-008 rs1_busy, rs2_busy  out  1 each  source has an unretired pending write.
REQ-009 wb_addr  in  5  writeback destination.
REQ-010 wb_data  in  32  writeback value.
REQ-011 wb_we  in  1  writeback write enable.
REQ-012 issue_valid  in  1  decode issues an instruction with RegWrite set.
REQ-013 issue_rd  in  5  destination of the issuing instruction.
REQ-014 issue_ready  out  1  issue can be accepted this cycle.
REQ-015 cancel_valid  in  1  a squashed in-flight writer is retired without writing.
REQ-016 cancel_rd  in  5  destination of the squashed writer.
REQ-017 sb_error  out  1  sticky: pending-counter underflow detected.

Function
REQ-018 Storage: 31 x 32-bit registers x1..x31; x0 reads 0, is never written, never busy.
REQ-019 Write: on a rising clk with wb_we=1 and wb_addr!=0, reg[wb_addr] takes wb_data; visible on reads the next cycle.
REQ-020 Read: rsN_data is combinational from rsN_addr; with BYPASS_EN=1, when wb_we=1, wb_addr!=0 and wb_addr==rsN_addr, rsN_data = wb_data in the same cycle.
REQ-021 Per-register pending counter cnt[r], r=1..31: +1 on accepted issue to r, -1 on wb_we to r, -1 on cancel_valid to r; all events in one cycle sum (issue+wb same r -> unchanged; wb+cancel same r -> -2).
REQ-022 Issue accepted iff issue_valid=1, issue_rd!=0 and issue_ready=1; issue_rd=0 is accepted with no counter change.
REQ-023 issue_ready = 0 iff issue_rd!=0 and cnt[issue_rd]==MAX_PENDING and no wb/cancel decrements issue_rd this cycle; otherwise 1.
REQ-024 A non-accepted issue changes no state.
REQ-025 rsN_busy = 1 iff rsN_addr!=0 and (cnt[rsN_addr] minus this-cycle wb/cancel decrements to rsN_addr) > 0; same-cycle issue does not affect busy.
REQ-026 Underflow: any decrement that would take cnt below 0 clamps cnt at 0 and sets sb_error=1 on that edge; sb_error holds until reset.
REQ-027 Writes or cancels to x0 are ignored; no state change.
REQ-028 Latency: data and busy are combinational on inputs plus current state; all state updates take effect at the next rising clk.

Reset
REQ-029 While reset=0: all registers 0, all cnt 0, sb_error 0; writes, issues and cancels are ignored.
REQ-030 Outputs during reset: rs1_data=rs2_data=0, rs1_busy=rs2_busy=0, issue_ready=1, sb_error=0.
REQ-031 Assertion mid-operation discards all pending state immediately (asynchronously); deassertion takes effect at the next rising clk.

Structure
REQ-032 Package regfile_pkg holds XLEN=32, NUM_REGS=32, REG_ADDR_W=5 and the default MAX_PENDING.
REQ-033 One sub-module pending_counter (saturating up/down counter with 1 increment and 2 decrement inputs, underflow flag), instantiated 31 times; storage and bypass stay in the top level.

Verification
REQ-034 Write 0xDEADBEEF to x5; next cycle read rs1_addr=5 -> rs1_data=0xDEADBEEF; same-cycle read during the write -> 0xDEADBEEF (bypass).
REQ-035 wb_we=1, wb_addr=0, data 0x1234 -> rs1_addr=0 reads 0; issue_rd=0 -> rs1_busy=0 and issue_ready=1.
REQ-036 Three issues to x7 -> rs2_busy=1, fourth issue to x7 -> issue_ready=0 and cnt unchanged; same-cycle issue+wb to x7 at cnt=3 -> accepted, cnt stays 3.
REQ-037 cnt[x9]=1, wb to x9 -> rs1_busy=0 that cycle with rs1_data=wb_data; cnt[x9]=1, wb and cancel to x9 together -> cnt=0, sb_error=1.
REQ-038 Two issues to x3, one cancel to x3, one wb to x3 -> busy 1,1,1,0 across the sequence; assert reset mid-sequence -> all busy 0, x3 reads 0.
